// File: rtl/uart_row_pkg.sv
// uart_row_pkg: protocol constants, FSM/phase/error types and ack lookup for the row sender
package uart_row_pkg;
  localparam logic [7:0] END_WORD   = 8'hDD;
  localparam logic [7:0] ACK_ROW    = 8'hCC;
  localparam logic [7:0] ACK_DATA   = 8'hAA;
  localparam logic [7:0] RESULT_OK  = 8'hBC;
  localparam logic [7:0] RESULT_NAK = 8'h11;
  typedef enum logic [2:0] {IDLE, LOAD, TX_REQ, TX_WAIT, RX_WAIT, FINISH} state_t;
  typedef enum logic [1:0] {P_START, P_ROW, P_DATA, P_END} phase_t;
  typedef enum logic [1:0] {E_NONE = 2'd0, E_TIMEOUT = 2'd1, E_BADACK = 2'd2, E_NAK = 2'd3} err_t;
  function automatic logic [7:0] expected_ack(input phase_t p);
    return p == P_END ? RESULT_OK : p == P_DATA ? ACK_DATA : ACK_ROW;
  endfunction
endpackage

// File: rtl/uart_row_timeout.sv
// uart_row_timeout: saturating reply-wait counter; expired_o once CYCLES-1 is reached
// Ports: clk, rst (async, active high), clr_i (sync clear), en_i (count), expired_o
module uart_row_timeout #(
  parameter int unsigned CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(CYCLES) < 1 ? 1 : $clog2(CYCLES);
  logic [W-1:0] cnt_q;
  assign expired_o = cnt_q == W'(CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && !expired_o) cnt_q <= cnt_q + W'(1);
endmodule

// File: rtl/uart_row_sender.sv
// uart_row_sender: sends start/row/payload/end bytes over a UART byte interface, checking each ack
// Ports: start_i/row_i/row_data_i request a row; tx_* drive the transmitter, rx_* come from the
// receiver; busy_o spans the transfer, done_o/err_o pulse at its end, err_code_o holds the cause.
module uart_row_sender
  import uart_row_pkg::*;
#(
  parameter int unsigned ROW_BYTES      = 240,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [8:0]             row_i,
  input  logic [8*ROW_BYTES-1:0] row_data_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_start_o,
  input  logic                   tx_busy_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_done_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [1:0]             err_code_o
);
  localparam logic [7:0] LAST = 8'(ROW_BYTES - 1);
  state_t state_q, state_d;
  phase_t phase_q, phase_d;
  err_t code_q, code_d;
  logic [7:0] idx_q, idx_d, tx_data_q, tx_data_d, tx_byte;
  logic [8:0] row_q, row_d;
  logic [8*ROW_BYTES-1:0] data_q, data_d;
  logic tx_start_q, tx_start_d, busy_q, busy_d, done_q, done_d, err_q, err_d, seen_q, seen_d;
  logic issue, expired;
  uart_row_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .rst(rst), .clr_i(state_q != RX_WAIT), .en_i(1'b1), .expired_o(expired)
  );
  assign tx_byte = phase_d == P_START ? {7'b0, row_q[8]} :
                   phase_d == P_ROW   ? row_q[7:0] :
                   phase_d == P_DATA  ? data_q[{idx_d, 3'b000} +: 8] : END_WORD;
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    row_d      = row_q;
    data_d     = data_q;
    code_d     = code_q;
    busy_d     = busy_q;
    seen_d     = seen_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    issue      = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        row_d   = row_i;
        data_d  = row_data_i;
        busy_d  = 1'b1;
        code_d  = E_NONE;
        state_d = LOAD;
      end
      LOAD: begin
        phase_d = P_START;
        idx_d   = '0;
        state_d = TX_REQ;
      end
      TX_REQ: issue = 1'b1;
      TX_WAIT: begin
        seen_d = seen_q | tx_busy_i;
        // the far end never acknowledges the last payload byte, so the end word follows directly
        if (seen_q && !tx_busy_i) begin
          phase_d = phase_q == P_DATA && idx_q == LAST ? P_END : phase_q;
          state_d = phase_q == P_DATA && idx_q == LAST ? TX_REQ : RX_WAIT;
        end
      end
      RX_WAIT:
        if (rx_done_i) begin
          if (rx_data_i != expected_ack(phase_q)) begin
            err_d   = 1'b1;
            code_d  = phase_q == P_END && rx_data_i == RESULT_NAK ? E_NAK : E_BADACK;
            busy_d  = 1'b0;
            state_d = FINISH;
          end else if (phase_q == P_END) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FINISH;
          end else begin
            // the next byte is launched in the ack cycle so its strobe follows rx_done directly
            phase_d = phase_q == P_START ? P_ROW : P_DATA;
            idx_d   = phase_q == P_DATA ? idx_q + 8'd1 : idx_q;
            issue   = 1'b1;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          code_d  = E_TIMEOUT;
          busy_d  = 1'b0;
          state_d = FINISH;
        end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      tx_start_d = 1'b1;
      tx_data_d  = tx_byte;
      seen_d     = 1'b0;
      state_d    = TX_WAIT;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= P_START;
      idx_q      <= '0;
      row_q      <= '0;
      data_q     <= '0;
      code_q     <= E_NONE;
      busy_q     <= 1'b0;
      seen_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      data_q     <= data_d;
      code_q     <= code_d;
      busy_q     <= busy_d;
      seen_q     <= seen_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;
endmodule

// File: tb/tb_uart_row_sender.sv
// tb_uart_row_sender: randomized bench with a transmitter/far-end responder and a protocol reference model
module tb_uart_row_sender;
  localparam int RB = 240, TO = 1000, LAST_J = RB + 1, END_J = RB + 2;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, tx_busy_i = 1'b0, rx_done_i = 1'b0;
  logic tx_start_o, busy_o, done_o, err_o;
  logic [8:0] row_i = '0;
  logic [8*RB-1:0] row_data_i = '0;
  logic [7:0] tx_data_o, rx_data_i = '0, final_v = 8'hBC;
  logic [1:0] err_code_o;
  int checks = 0, errors = 0;
  logic [7:0] sent[$];
  int base = 0, bad_j = -1, silent_j = -1;
  int lat_bad = 0, proto_bad = 0, n_done = 0, n_err = 0;
  int left = 0, wait_r = 0, cur_j = 0, exp_next = 0;
  logic prev_start = 1'b0;
  time fall_t = 0;
  uart_row_sender #(.ROW_BYTES(RB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .row_i(row_i), .row_data_i(row_data_i),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_busy_i(tx_busy_i),
    .rx_data_i(rx_data_i), .rx_done_i(rx_done_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_code_o(err_code_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] want(input int j);
    return j < 2 ? 8'hCC : j < END_J ? 8'hAA : 8'hBC;
  endfunction
  function automatic logic [7:0] reply(input int j);
    return j == bad_j ? 8'hAB : j == END_J ? final_v : want(j);
  endfunction
  initial forever begin
    @(negedge clk);
    n_done += int'(done_o);
    n_err  += int'(err_o);
    if (!rst && exp_next == 1 && !tx_start_o) lat_bad++;
    if (!rst && exp_next == 2 && !(done_o || err_o)) lat_bad++;
    if (tx_start_o && (prev_start || tx_busy_i)) proto_bad++;
    prev_start = tx_start_o;
    exp_next = 0;
    rx_done_i = 1'b0;
    if (rst) begin
      tx_busy_i = 1'b0;
      left = 0;
      wait_r = 0;
    end else if (tx_start_o) begin
      cur_j = sent.size() - base;
      sent.push_back(tx_data_o);
      tx_busy_i = 1'b1;
      left = $urandom_range(2, 5);
      wait_r = 0;
    end else if (tx_busy_i) begin
      if (left == 0) begin
        tx_busy_i = 1'b0;
        fall_t = $time;
        if (cur_j != LAST_J && cur_j != silent_j) wait_r = $urandom_range(1, 4);
      end else begin
        left--;
        if ($urandom_range(0, 5) == 0) begin
          rx_done_i = 1'b1;
          rx_data_i = 8'($urandom);
        end
      end
    end else if (wait_r > 0) begin
      wait_r--;
      if (wait_r == 0) begin
        rx_done_i = 1'b1;
        rx_data_i = reply(cur_j);
        exp_next = rx_data_i == want(cur_j) && cur_j != END_J ? 1 : 2;
      end
    end
  end
  task automatic xfer(input logic [8:0] r, input bit ipay, input logic [7:0] fin,
                      input int bad, input int sil, input int poke, input int rstj);
    logic [7:0] pay [RB];
    int len, ndone, code, d0, e0, l0, p0, n;
    bit hit, poked;
    logic got_done;
    logic [1:0] got_code;
    time t_err;
    final_v = fin;
    bad_j = bad;
    silent_j = sil;
    for (int k = 0; k < RB; k++) begin
      pay[k] = ipay ? 8'(k) : 8'($urandom);
      row_data_i[8*k +: 8] = pay[k];
    end
    len = 0;
    ndone = 0;
    code = 0;
    for (int j = 0; j <= END_J; j++) begin
      len = j + 1;
      if (j == LAST_J) continue;
      if (j == sil) begin code = 1; break; end
      if (j == END_J) begin
        ndone = reply(j) == 8'hBC ? 1 : 0;
        code = reply(j) == 8'hBC ? 0 : reply(j) == 8'h11 ? 3 : 2;
        break;
      end
      if (reply(j) != want(j)) begin code = 2; break; end
    end
    @(negedge clk);
    base = sent.size();
    d0 = n_done;
    e0 = n_err;
    l0 = lat_bad;
    p0 = proto_bad;
    row_i = r;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_rise", busy_o, 1);
    check("code_clear", err_code_o, 0);
    repeat (2) @(negedge clk);
    check("start_lat", tx_start_o, 1);
    hit = 0;
    poked = 0;
    got_done = 1'bx;
    got_code = 2'bxx;
    t_err = 0;
    for (int c = 0; c < 20000 && !hit; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      n = sent.size() - base;
      if (rstj >= 0 && n > rstj) begin
        check("busy_before_rst", busy_o, 1);
        rst = 1'b1;
        #1;
        check("rst_async", {tx_data_o, tx_start_o, busy_o, done_o, err_o, err_code_o}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (done_o || err_o) begin
        hit = 1;
        got_done = done_o;
        got_code = err_code_o;
        t_err = $time;
        check("busy_fall", busy_o, 0);
      end else if (poke >= 0 && !poked && n > poke) begin
        poked = 1;
        start_i = 1'b1;
        row_i = '0;
        row_data_i = '0;
      end
    end
    check("finished", hit, 1);
    repeat (6) @(negedge clk);
    check("done", got_done, ndone);
    check("code", got_code, code);
    check("code_hold", err_code_o, code);
    check("n_done", n_done - d0, ndone);
    check("n_err", n_err - e0, 1 - ndone);
    check("len", sent.size() - base, len);
    for (int j = 0; j < len && base + j < sent.size(); j++)
      check($sformatf("byte%0d", j), sent[base+j],
            j == 0 ? {7'b0, r[8]} : j == 1 ? r[7:0] : j < END_J ? pay[j-2] : 8'hDD);
    check("ack_lat", lat_bad - l0, 0);
    check("proto", proto_bad - p0, 0);
    check("busy_end", busy_o, 0);
    if (sil >= 0) check("timeout_cyc", int'((t_err - fall_t) / 10) - 1, TO);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_out", {tx_data_o, tx_start_o, busy_o, done_o, err_o, err_code_o}, 0);
    rst = 1'b0;
    xfer(9'h105, 1'b1, 8'hBC, -1, -1, -1, -1);
    xfer(9'h105, 1'b1, 8'h11, -1, -1, -1, -1);
    xfer(9'($urandom), 1'b0, 8'hBC, 12, -1, -1, -1);
    xfer(9'($urandom), 1'b0, 8'hBC, -1, 1, -1, -1);
    xfer(9'($urandom), 1'b0, 8'hBC, -1, -1, 50, -1);
    xfer(9'($urandom), 1'b0, 8'hBC, -1, -1, -1, 102);
    for (int i = 0; i < 3; i++) xfer(9'($urandom), 1'b0, 8'hBC, -1, -1, -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
